// File: rtl/ysyx_22050039_idu_pkg.sv
// Shared types for the pipelined IDU: function codes, instruction-type one-hots,
// FSM states, opcodes and the registered decode bundle.
// No logic; imported by the interface, the GPR file and the IDU top.
`ifndef ysyx_22050039_FUNC_LEN
`define ysyx_22050039_FUNC_LEN 3
`endif

package ysyx_22050039_idu_pkg;

   localparam int XLEN     = 64;
   localparam int INST_LEN = 32;
   localparam int NR_REG   = 32;
   localparam int REG_SEL  = $clog2(NR_REG);
   localparam int FUNC_LEN = `ysyx_22050039_FUNC_LEN;

   typedef enum logic [FUNC_LEN-1:0] {
      Addi, Jalr, Sd, Auipc, Lui, Jal, Ebreak, Inv
   } func_e;

   // Instruction-format one-hots
   localparam logic [6:0] Rtype   = 7'b000_0001;
   localparam logic [6:0] Itype   = 7'b000_0010;
   localparam logic [6:0] Stype   = 7'b000_0100;
   localparam logic [6:0] Btype   = 7'b000_1000;
   localparam logic [6:0] Utype   = 7'b001_0000;
   localparam logic [6:0] Jtype   = 7'b010_0000;
   localparam logic [6:0] Special = 7'b100_0000;

   typedef enum logic {RUN, HALT} state_e;

   localparam logic [6:0]          OP_IMM     = 7'b0010011;
   localparam logic [6:0]          OP_JALR    = 7'b1100111;
   localparam logic [6:0]          OP_STORE   = 7'b0100011;
   localparam logic [6:0]          OP_AUIPC   = 7'b0010111;
   localparam logic [6:0]          OP_LUI     = 7'b0110111;
   localparam logic [6:0]          OP_JAL     = 7'b1101111;
   localparam logic [6:0]          OP_SYSTEM  = 7'b1110011;
   localparam logic [INST_LEN-1:0] EBREAK_INST = 32'h0010_0073;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [XLEN-1:0]    src1;
      logic [XLEN-1:0]    src2;
      logic [REG_SEL-1:0] rd;
      func_e              func;
      logic               pc_wen;
      logic               reg_wen;
   } bundle_t;

   // Format of each supported function; everything unrecognised is Special.
   function automatic logic [6:0] type_of(input func_e f);
      case (f)
         Addi, Jalr:  return Itype;
         Sd:          return Stype;
         Auipc, Lui:  return Utype;
         Jal:         return Jtype;
         default:     return Special;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_22050039_idu_if.sv
// IFU->IDU, IDU->EXU and writeback signal group.
// slave: the IDU view. master: the surrounding pipeline (IFU/EXU/WB) view.
// Handshakes are valid/ready; the writeback strobe has no backpressure.
interface ysyx_22050039_idu_if;
   import ysyx_22050039_idu_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [INST_LEN-1:0] inst;
   logic [XLEN-1:0]     pc;

   logic                out_valid;
   logic                out_ready;
   logic [XLEN-1:0]     out_pc;
   logic [XLEN-1:0]     src1;
   logic [XLEN-1:0]     src2;
   logic [REG_SEL-1:0]  out_rd;
   func_e               func;
   logic                pc_wen;
   logic                reg_wen;

   logic                wb_en;
   logic [REG_SEL-1:0]  wb_rd;
   logic [XLEN-1:0]     wb_data;

   modport slave (
      input  in_valid, inst, pc, out_ready, wb_en, wb_rd, wb_data,
      output in_ready, out_valid, out_pc, src1, src2, out_rd, func, pc_wen, reg_wen
   );

   modport master (
      output in_valid, inst, pc, out_ready, wb_en, wb_rd, wb_data,
      input  in_ready, out_valid, out_pc, src1, src2, out_rd, func, pc_wen, reg_wen
   );
endinterface

// File: rtl/ysyx_22050039_gpr.sv
// GPR file: NR_REG x XLEN, two combinational read ports, one posedge write port.
// Latency: reads 0 cycles, writes visible the cycle after the strobe.
// Backpressure: none; writes are always taken. x0 reads 0 and ignores writes.
// Ports: clk, rst (sync active-low), wen/waddr/wdata, raddr1/2 -> rdata1/2.
// YSYX_22050039_IDU_BYPASS_EN forwards same-cycle write data to the read ports.
module ysyx_22050039_gpr
   import ysyx_22050039_idu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               wen,
   input  logic [REG_SEL-1:0] waddr,
   input  logic [XLEN-1:0]    wdata,
   input  logic [REG_SEL-1:0] raddr1,
   input  logic [REG_SEL-1:0] raddr2,
   output logic [XLEN-1:0]    rdata1,
   output logic [XLEN-1:0]    rdata2
);
   logic [XLEN-1:0] regs [NR_REG];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NR_REG; i++) regs[i] <= '0;
      end else if (wen && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
      rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
`ifdef YSYX_22050039_IDU_BYPASS_EN
      if (wen && raddr1 != '0 && raddr1 == waddr) rdata1 = wdata;
      if (wen && raddr2 != '0 && raddr2 == waddr) rdata2 = wdata;
`endif
   end
endmodule

// File: rtl/ysyx_22050039_idu_pipe.sv
// Pipelined IDU: decodes addi/jalr/sd/auipc/lui/jal/ebreak, owns the GPRs and a busy scoreboard.
// Latency: 1 cycle from accept to out_valid (single output register).
// Backpressure: in_ready drops on RAW/WAW hazard, on halt, or while a held bundle is not consumed.
// Ports: clk, rst (sync active-low); bus (slave modport: in/out handshakes, bundle, writeback);
//        halted (sticky ebreak/invalid), inv_inst (halt cause was invalid).
// YSYX_22050039_IDU_BYPASS_EN: forward writeback data and ignore busy for a source written this cycle.
module ysyx_22050039_idu_pipe
   import ysyx_22050039_idu_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   ysyx_22050039_idu_if.slave  bus,
   output logic                halted,
   output logic                inv_inst
);
   state_e             state, state_nxt;
   logic [NR_REG-1:0]  busy, busy_nxt;
   bundle_t            out_q, dec;
   logic               out_valid_q, inv_q;

   logic [6:0]         opcode, itype;
   logic [2:0]         funct3;
   logic [REG_SEL-1:0] rs1, rs2, rd_f;
   func_e              func_d;
   logic [XLEN-1:0]    rdata1, rdata2, imm_i, imm_u, imm_j;
   logic               is_i, is_s, is_u, is_j, writes_rd, stop_d;
   logic               busy_rs1, busy_rs2, hazard, accept;

   assign opcode = bus.inst[6:0];
   assign funct3 = bus.inst[14:12];
   assign rd_f   = bus.inst[7 +: REG_SEL];
   assign rs1    = bus.inst[15 +: REG_SEL];
   assign rs2    = bus.inst[20 +: REG_SEL];

   assign imm_i = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:20]};
   assign imm_u = {{(XLEN-32){bus.inst[31]}}, bus.inst[31:12], 12'b0};
   assign imm_j = {{(XLEN-21){bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                   bus.inst[20], bus.inst[30:21], 1'b0};

   ysyx_22050039_gpr u_gpr (
      .clk    (clk),
      .rst    (rst),
      .wen    (bus.wb_en),
      .waddr  (bus.wb_rd),
      .wdata  (bus.wb_data),
      .raddr1 (rs1),
      .raddr2 (rs2),
      .rdata1 (rdata1),
      .rdata2 (rdata2)
   );

   always_comb begin
      func_d = Inv;
      case (opcode)
         OP_IMM:    if (funct3 == 3'b000) func_d = Addi;
         OP_JALR:   if (funct3 == 3'b000) func_d = Jalr;
         OP_STORE:  if (funct3 == 3'b011) func_d = Sd;
         OP_AUIPC:  func_d = Auipc;
         OP_LUI:    func_d = Lui;
         OP_JAL:    func_d = Jal;
         OP_SYSTEM: if (bus.inst == EBREAK_INST) func_d = Ebreak;
         default:   func_d = Inv;
      endcase
   end

   assign itype     = type_of(func_d);
   assign is_i      = |(itype & Itype);
   assign is_s      = |(itype & Stype);
   assign is_u      = |(itype & Utype);
   assign is_j      = |(itype & Jtype);
   assign writes_rd = is_i | is_u | is_j;
   assign stop_d    = (func_d == Ebreak) | (func_d == Inv);

   // Bundle as it will be registered on accept; unused fields stay 0.
   always_comb begin
      dec         = '0;
      dec.pc      = bus.pc;
      dec.func    = func_d;
      dec.pc_wen  = (func_d == Jal) | (func_d == Jalr);
      dec.reg_wen = writes_rd & (rd_f != '0);
      if (writes_rd) dec.rd = rd_f;
      if (is_i) begin
         dec.src1 = rdata1;
         dec.src2 = imm_i;
      end else if (is_s) begin
         dec.src1 = rdata1;
         dec.src2 = rdata2;
      end else if (is_u) begin
         dec.src1 = imm_u;
      end else if (is_j) begin
         dec.src1 = imm_j;
      end
   end

`ifdef YSYX_22050039_IDU_BYPASS_EN
   // A source being written back this cycle is served by the forwarded value.
   assign busy_rs1 = busy[rs1] & ~(bus.wb_en & (bus.wb_rd == rs1));
   assign busy_rs2 = busy[rs2] & ~(bus.wb_en & (bus.wb_rd == rs2));
`else
   assign busy_rs1 = busy[rs1];
   assign busy_rs2 = busy[rs2];
`endif

   assign hazard = ((is_i | is_s) & busy_rs1) | (is_s & busy_rs2) | (dec.reg_wen & busy[rd_f]);
   // rst gates in_ready so nothing is taken while reset is asserted.
   assign bus.in_ready = rst & (state == RUN) & ~hazard & (~out_valid_q | bus.out_ready);
   assign accept       = bus.in_valid & bus.in_ready;

   // Clear first, then set, so a same-cycle set of the same index wins.
   always_comb begin
      busy_nxt = busy;
      if (bus.wb_en) busy_nxt[bus.wb_rd] = 1'b0;
      if (accept && dec.reg_wen) busy_nxt[rd_f] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_comb begin
      state_nxt = state;
      if (state == RUN && accept && stop_d) state_nxt = HALT;
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= RUN;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         busy        <= '0;
         inv_q       <= 1'b0;
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= dec;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         busy <= busy_nxt;
         if (accept && func_d == Inv) inv_q <= 1'b1;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_pc    = out_q.pc;
   assign bus.src1      = out_q.src1;
   assign bus.src2      = out_q.src2;
   assign bus.out_rd    = out_q.rd;
   assign bus.func      = out_q.func;
   assign bus.pc_wen    = out_q.pc_wen;
   assign bus.reg_wen   = out_q.reg_wen;
   assign halted        = (state == HALT);
   assign inv_inst      = inv_q;
endmodule

// File: tb/tb_ysyx_22050039_idu_pipe.sv
// Bench for the pipelined IDU: directed vectors with literal expectations, plus a
// cycle-level reference model compared against every output on each falling edge.
module tb_ysyx_22050039_idu_pipe;
   import ysyx_22050039_idu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic halted, inv_inst;
   int   checks = 0;
   int   errors = 0;

   ysyx_22050039_idu_if bus();

   ysyx_22050039_idu_pipe dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .halted   (halted),
      .inv_inst (inv_inst)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [2:0]  f;
      logic [63:0] pc, s1, s2;
      logic [4:0]  rd;
      logic        wen, pcw, u1, u2, stop, bad;
   } mdec_t;

   logic [63:0] m_reg [32] = '{default: '0};
   logic [31:0] m_busy = '0;
   logic        m_ov = 1'b0, m_halt = 1'b0, m_inv = 1'b0, m_show = 1'b1;
   mdec_t       m_b = '0;

   function automatic logic [63:0] opnd(input logic [4:0] r);
      if (r == 5'd0) return 64'd0;
`ifdef YSYX_22050039_IDU_BYPASS_EN
      if (bus.wb_en && bus.wb_rd == r) return bus.wb_data;
`endif
      return m_reg[r];
   endfunction

   function automatic logic busy_of(input logic [4:0] r);
      logic b = m_busy[r];
`ifdef YSYX_22050039_IDU_BYPASS_EN
      if (bus.wb_en && bus.wb_rd == r) b = 1'b0;
`endif
      return b;
   endfunction

   function automatic mdec_t mdec(input logic [31:0] i, input logic [63:0] p);
      mdec_t d = '0;
      d.pc = p;
      if (i == 32'h0010_0073) begin
         d.f = Ebreak; d.stop = 1'b1;
      end else begin
         casez (i)
            32'b?????????????????000?????0010011: begin
               d.f = Addi; d.u1 = 1'b1; d.rd = i[11:7];
               d.s1 = opnd(i[19:15]); d.s2 = 64'($signed(i[31:20]));
            end
            32'b?????????????????000?????1100111: begin
               d.f = Jalr; d.u1 = 1'b1; d.rd = i[11:7]; d.pcw = 1'b1;
               d.s1 = opnd(i[19:15]); d.s2 = 64'($signed(i[31:20]));
            end
            32'b?????????????????011?????0100011: begin
               d.f = Sd; d.u1 = 1'b1; d.u2 = 1'b1;
               d.s1 = opnd(i[19:15]); d.s2 = opnd(i[24:20]);
            end
            32'b?????????????????????????0010111: begin
               d.f = Auipc; d.rd = i[11:7]; d.s1 = 64'($signed({i[31:12], 12'b0}));
            end
            32'b?????????????????????????0110111: begin
               d.f = Lui; d.rd = i[11:7]; d.s1 = 64'($signed({i[31:12], 12'b0}));
            end
            32'b?????????????????????????1101111: begin
               d.f = Jal; d.rd = i[11:7]; d.pcw = 1'b1;
               d.s1 = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            default: begin
               d.f = Inv; d.stop = 1'b1; d.bad = 1'b1;
            end
         endcase
      end
      d.wen = (d.rd != 5'd0);
      return d;
   endfunction

   always @(negedge clk) begin
      mdec_t d;
      logic  haz, exp_rdy, acc;
      d   = mdec(bus.inst, bus.pc);
      haz = (d.u1 && busy_of(bus.inst[19:15])) || (d.u2 && busy_of(bus.inst[24:20]))
            || (d.wen && m_busy[d.rd]);
      exp_rdy = rst && !m_halt && !haz && (!m_ov || bus.out_ready);
      chk("m_in_ready", bus.in_ready, exp_rdy);
      chk("m_out_valid", bus.out_valid, m_ov);
      chk("m_halted", halted, m_halt);
      chk("m_inv_inst", inv_inst, m_inv);
      if (m_ov || m_show) begin
         chk("m_out_pc", bus.out_pc, m_b.pc);
         chk("m_src1", bus.src1, m_b.s1);
         chk("m_src2", bus.src2, m_b.s2);
         chk("m_out_rd", bus.out_rd, m_b.rd);
         chk("m_func", bus.func, m_b.f);
         chk("m_pc_wen", bus.pc_wen, m_b.pcw);
         chk("m_reg_wen", bus.reg_wen, m_b.wen);
      end
      if (!rst) begin
         m_ov = 1'b0; m_halt = 1'b0; m_inv = 1'b0; m_show = 1'b1;
         m_b = '0; m_busy = '0;
         for (int k = 0; k < 32; k++) m_reg[k] = '0;
      end else begin
         acc = bus.in_valid && exp_rdy;
         if (acc) begin
            m_ov = 1'b1; m_b = d; m_show = 1'b0;
            if (d.stop) m_halt = 1'b1;
            if (d.bad)  m_inv  = 1'b1;
         end else if (bus.out_ready) begin
            m_ov = 1'b0;
         end
         if (bus.wb_en) m_busy[bus.wb_rd] = 1'b0;
         if (acc && d.wen) m_busy[d.rd] = 1'b1;
         if (bus.wb_en && bus.wb_rd != 5'd0) m_reg[bus.wb_rd] = bus.wb_data;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input logic [31:0] i, input logic [63:0] p, output int waited);
      waited = 0;
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.inst = i; bus.pc = p;
      #1;
      while (!bus.in_ready && waited < 20) begin
         @(posedge clk); #2;
         waited++;
      end
      chk("issue_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      #1;
   endtask

   task automatic wb(input logic [4:0] r, input logic [63:0] v);
      @(posedge clk); #1;
      bus.wb_en = 1'b1; bus.wb_rd = r; bus.wb_data = v;
      @(posedge clk); #1;
      bus.wb_en = 1'b0;
   endtask

   task automatic rst_pulse();
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      #1;
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int w;
      bus.in_valid = 1'b1; bus.inst = 32'h0050_0093; bus.pc = 64'h8000_0000;
      bus.out_ready = 1'b1; bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;

      // 1: reset held with in_valid high
      repeat (2) @(posedge clk);
      #2;
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_halted", halted, 1'b0);
      for (int k = 0; k < 32; k++) chk("rst_reg", dut.u_gpr.regs[k], 64'd0);
      rst = 1'b1; bus.in_valid = 1'b0;

      // 2: addi x1,x0,5
      issue(32'h0050_0093, 64'h8000_0000, w);
      chk("addi_valid", bus.out_valid, 1'b1);
      chk("addi_func", bus.func, Addi);
      chk("addi_src1", bus.src1, 64'd0);
      chk("addi_src2", bus.src2, 64'd5);
      chk("addi_rd", bus.out_rd, 5'd1);
      chk("addi_wen", bus.reg_wen, 1'b1);
      chk("addi_pc", bus.out_pc, 64'h8000_0000);

      // 3: addi x2,x1,1 stalls on busy x1 until writeback
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.inst = 32'h0010_8113; bus.pc = 64'h8000_0004;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("raw_stall", bus.in_ready, 1'b0);
         @(posedge clk); #2;
      end
      bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 64'd5;
      #1;
`ifdef YSYX_22050039_IDU_BYPASS_EN
      chk("raw_wb_cycle_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      bus.wb_en = 1'b0; bus.in_valid = 1'b0;
      #1;
`else
      chk("raw_wb_cycle_stall", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      bus.wb_en = 1'b0;
      #1;
      chk("raw_after_wb_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      #1;
`endif
      chk("raw_valid", bus.out_valid, 1'b1);
      chk("raw_src1", bus.src1, 64'd5);
      chk("raw_src2", bus.src2, 64'd1);
      chk("raw_rd", bus.out_rd, 5'd2);
      wb(5'd2, 64'd6);

      // 4: backpressure on lui x3,0x12345, then same-cycle refill with addi x4,x0,7
      bus.out_ready = 1'b0;
      issue(32'h1234_51B7, 64'h8000_0008, w);
      bus.in_valid = 1'b1; bus.inst = 32'h0070_0213; bus.pc = 64'h8000_000C;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("bp_valid", bus.out_valid, 1'b1);
         chk("bp_src1", bus.src1, 64'h1234_5000);
         chk("bp_func", bus.func, Lui);
         chk("bp_in_ready", bus.in_ready, 1'b0);
         @(posedge clk); #3;
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      #1;
      chk("refill_valid", bus.out_valid, 1'b1);
      chk("refill_src2", bus.src2, 64'd7);
      chk("refill_rd", bus.out_rd, 5'd4);

      // 5: ebreak halts; presented once; reset recovers
      issue(32'h0010_0073, 64'h8000_0010, w);
      chk("ebreak_valid", bus.out_valid, 1'b1);
      chk("ebreak_func", bus.func, Ebreak);
      chk("ebreak_halted", halted, 1'b1);
      chk("ebreak_inv", inv_inst, 1'b0);
      bus.in_valid = 1'b1; bus.inst = 32'h0070_0293;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #2;
         chk("halt_in_ready", bus.in_ready, 1'b0);
         if (k == 0) chk("ebreak_once", bus.out_valid, 1'b0);
      end
      bus.in_valid = 1'b0;
      rst_pulse();
      chk("rerun_halted", halted, 1'b0);
      chk("rerun_in_ready", bus.in_ready, 1'b1);

      // 6: invalid instruction, then addi x0 writes nothing
      issue(32'hFFFF_FFFF, 64'h8000_0014, w);
      chk("inv_func", bus.func, Inv);
      chk("inv_halted", halted, 1'b1);
      chk("inv_inst", inv_inst, 1'b1);
      rst_pulse();
      issue(32'h0010_0013, 64'h8000_0018, w);
      chk("x0_reg_wen", bus.reg_wen, 1'b0);
      issue(32'h0010_0013, 64'h8000_001C, w);
      chk("x0_no_busy_wait", w, 0);

      // 7: remaining formats
      wb(5'd1, 64'h100);
      wb(5'd2, 64'hABC);
      issue(32'h0020_B423, 64'h8000_0020, w);
      chk("sd_func", bus.func, Sd);
      chk("sd_src1", bus.src1, 64'h100);
      chk("sd_src2", bus.src2, 64'hABC);
      chk("sd_wen", bus.reg_wen, 1'b0);
      issue(32'h0100_00EF, 64'h8000_0024, w);
      chk("jal_src1", bus.src1, 64'd16);
      chk("jal_pc_wen", bus.pc_wen, 1'b1);
      chk("jal_rd", bus.out_rd, 5'd1);
      issue(32'hFFC1_02E7, 64'h8000_0028, w);
      chk("jalr_src1", bus.src1, 64'hABC);
      chk("jalr_src2", bus.src2, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("jalr_rd", bus.out_rd, 5'd5);
      issue(32'h8000_0397, 64'h8000_002C, w);
      chk("auipc_src1", bus.src1, 64'hFFFF_FFFF_8000_0000);
      chk("auipc_func", bus.func, Auipc);

      repeat (3) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
